// File: rtl/pattern_bit_serializer.sv
// Parallel-to-serial front end for the serial pattern detectors.
// Words arrive over valid/ready. They leave one bit per enabled clock on dout.
// A one-word holding buffer lets consecutive words follow each other with no
// idle bit in between.
module pattern_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             en,
    output logic             dout,
    output logic             dout_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] hold_reg, hold_next;
    logic             hold_full, hold_full_next;
    logic [CW-1:0]    bit_cnt, bit_cnt_next;

    logic accept;
    logic complete;
    logic send_bit;

    // s_ready depends only on the registered hold flag, so there is no
    // combinational path from en or s_valid to s_ready.
    assign s_ready  = !hold_full;
    assign accept   = s_valid && s_ready;
    assign complete = (state == SHIFT) && en && (bit_cnt == CNT_LAST);
    assign send_bit = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

    // All outputs are decoded from registers. An asynchronous reset therefore
    // forces them to idle values at once.
    assign dout_valid = (state == SHIFT);
    assign dout       = dout_valid && send_bit;
    assign last       = dout_valid && (bit_cnt == CNT_LAST);
    assign busy       = (state == SHIFT) || hold_full;

    // State register; reset discards any partial word and the held word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            hold_reg  <= hold_next;
            hold_full <= hold_full_next;
            bit_cnt   <= bit_cnt_next;
        end
    end

    // Next-state logic. s_data is only copied on an accept, so a word that
    // was not accepted (or an X on s_data) never reaches the datapath.
    always_comb begin
        state_next     = state;
        shift_next     = shift_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full;
        bit_cnt_next   = bit_cnt;

        unique case (state)
            IDLE: begin
                // The load does not wait for en. The first bit shows on the
                // next cycle.
                if (accept) begin
                    shift_next   = s_data;
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (complete) begin
                    // Refill with no bubble. The held word wins. A new word can
                    // only arrive here when the holding buffer is empty.
                    bit_cnt_next = '0;
                    if (hold_full) begin
                        shift_next     = hold_reg;
                        hold_full_next = 1'b0;
                    end else if (accept) begin
                        shift_next = s_data;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (en) begin
                        bit_cnt_next = bit_cnt + CW'(1);
                        if (MSB_FIRST)
                            shift_next = {shift_reg[WIDTH-2:0], 1'b0};
                        else
                            shift_next = {1'b0, shift_reg[WIDTH-1:1]};
                    end
                    // Words accepted mid-word, stalled or not, wait in the buffer.
                    if (accept) begin
                        hold_next      = s_data;
                        hold_full_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pattern_bit_serializer.sv
// Bench for pattern_bit_serializer.
// DUT a is MSB-first and is checked against a scoreboard queue of expected bits.
// DUT b is LSB-first and is checked cycle by cycle from a vector table.
module tb_pattern_bit_serializer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // MSB-first instance
    logic       a_valid, a_ready, a_en, a_dout, a_dv, a_last, a_busy;
    logic [7:0] a_data;
    // LSB-first instance
    logic       b_valid, b_ready, b_en, b_dout, b_dv, b_last, b_busy;
    logic [7:0] b_data;

    pattern_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .s_valid(a_valid), .s_ready(a_ready),
        .s_data(a_data), .en(a_en), .dout(a_dout), .dout_valid(a_dv),
        .last(a_last), .busy(a_busy));

    pattern_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .s_valid(b_valid), .s_ready(b_ready),
        .s_data(b_data), .en(b_en), .dout(b_dout), .dout_valid(b_dv),
        .last(b_last), .busy(b_busy));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic b;
        logic l;
    } exp_bit_t;
    exp_bit_t sb[$];

    bit mon_on  = 1'b0;
    int vcnt    = 0;
    bit det_on  = 1'b0;
    int det_st  = 0;
    int z_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor. It pops one expected bit each time en lets a bit go.
    always @(negedge clk) begin
        if (mon_on && !reset) begin
            logic [3:0] exp;
            exp = (sb.size() > 0) ? {1'b1, sb[0].b, sb[0].l, 1'b1} : 4'b0000;
            check("a_dv_dout_last_busy", {28'd0, a_dv, a_dout, a_last, a_busy}, {28'd0, exp});
            if (a_dv) vcnt++;
            if (sb.size() > 0 && a_en) void'(sb.pop_front());
        end
    end

    // Reference 1011 overlapping Mealy detector fed from dout.
    always @(posedge clk) begin
        if (det_on && a_dv && a_en) begin
            case (det_st)
                0: det_st = a_dout ? 1 : 0;
                1: det_st = a_dout ? 1 : 2;
                2: det_st = a_dout ? 3 : 0;
                default: begin
                    if (a_dout) begin z_cnt++; det_st = 1; end
                    else det_st = 2;
                end
            endcase
        end
    end

    // Present a word to DUT a. Wait (bounded) for s_ready, then queue its bits
    // at the accept edge. exp_wait is the number of cycles s_ready should be low.
    task automatic send(input logic [7:0] d, input int exp_wait);
        int n = 0;
        a_valid = 1'b1;
        a_data  = d;
        forever begin
            @(negedge clk);
            if (a_ready) break;
            n++;
            if (n > 40) break;
        end
        check("ready_wait", n, exp_wait);
        @(posedge clk);
        for (int i = 7; i >= 0; i--) sb.push_back('{d[i], (i == 0)});
        #1;
        a_valid = 1'b0;
        a_data  = 'x;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", (n >= 100), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e;
        logic       xd;
        logic       ed, ev, el, er;
    } vec_t;
    vec_t tbl[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
        $fatal(1);
    end

    initial begin
        // LSB-first vectors for word 8'h0D with a one-cycle stall on bit 3.
        tbl[0]  = '{1'b1, 8'h0D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        reset   = 1'b1;
        a_valid = 1'b0; a_data = '0; a_en = 1'b1;
        b_valid = 1'b0; b_data = '0; b_en = 1'b1;
        #1;
        check("reset_a", {27'd0, a_dout, a_dv, a_last, a_busy, a_ready}, 32'h1);
        check("reset_b", {27'd0, b_dout, b_dv, b_last, b_busy, b_ready}, 32'h1);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_on = 1'b1;
        @(posedge clk); #1;

        // Single word 8'hB0, MSB first. One detector hit is expected.
        det_on = 1'b1; det_st = 0; z_cnt = 0;
        send(8'hB0, 0);
        drain();
        det_on = 1'b0;
        check("z_pulses", z_cnt, 1);

        // Three words with s_valid held. The third waits for the first completion.
        vcnt = 0;
        send(8'hB0, 0);
        send(8'h0B, 0);
        send(8'hA5, 7);
        drain();
        check("b2b_valid_cycles", vcnt, 24);

        // Stall for 3 cycles while bit 3 of 8'hB0 (a 1) is on dout.
        vcnt = 0;
        send(8'hB0, 0);
        repeat (3) @(posedge clk);
        #1 a_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 a_en = 1'b1;
        drain();
        check("stall_valid_cycles", vcnt, 11);

        // Reset mid-word with the holding buffer full.
        send(8'hFF, 0);
        send(8'h55, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check("midrun_reset", {27'd0, a_dout, a_dv, a_last, a_busy, a_ready}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        vcnt = 0;
        send(8'h80, 0);
        drain();
        check("post_reset_valid_cycles", vcnt, 8);
        mon_on = 1'b0;

        // LSB-first table. s_data is X whenever s_valid is low.
        for (int i = 0; i < 11; i++) begin
            b_valid = tbl[i].v;
            b_data  = tbl[i].xd ? 8'hxx : tbl[i].d;
            b_en    = tbl[i].e;
            @(negedge clk);
            check($sformatf("lsb_row%0d", i), {28'd0, b_dv, b_dout, b_last, b_ready},
                  {28'd0, tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].er});
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
